sd_sector_server: RTL and testbench

Sector-level responder for the `sd_lba` / `sd_rd` / `sd_wr` / `sd_ack` block-transfer protocol that the save-RAM backup logic initiates. It replaces the SPI-host side with a local byte-wide backing store. The block works one 512-byte sector per request:

- **Reads:** it streams the sector into the initiator's buffer RAM.
- **Writes:** it pulls the sector out of the initiator's buffer RAM.

It sits between the save-RAM state machine and an external synchronous byte store, for example a BRAM or SDRAM shadow of the `.SAV` image.

---
 rtl/sd_sector_server.sv | 149 ++++++++++++++
 tb/tb_sd_sector_server.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_server.sv
// Sector responder for the sd_lba/sd_rd/sd_wr/sd_ack protocol, backed by a byte-wide synchronous store.
// One 512-byte sector per request; reads stream store->buffer, writes pull buffer->store.
module sd_sector_server #(
   parameter int LBA_BITS    = 4,
   parameter int START_DELAY = 2,
   parameter int STROBE_DIV  = 1
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [31:0]           sd_lba,
   input  logic                  sd_rd,
   input  logic                  sd_wr,
   output logic                  sd_ack,
   output logic [8:0]            sd_buff_addr,
   output logic [7:0]            sd_buff_dout,
   output logic                  sd_buff_wr,
   input  logic [7:0]            sd_buff_din,
   output logic [LBA_BITS+8:0]   store_addr,
   output logic                  store_we,
   output logic [7:0]            store_d,
   input  logic [7:0]            store_q,
   output logic                  range_err
);

   localparam int SW = $clog2(START_DELAY) + 1;
   localparam int DW = $clog2(STROBE_DIV) + 1;
   localparam logic [SW-1:0] SD_LAST  = SW'(START_DELAY - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(STROBE_DIV - 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
   state_t state, state_nx;

   logic [LBA_BITS-1:0] lba_q;
   logic                is_rd;
   logic                in_rng;
   logic [SW-1:0]       dly_cnt;
   logic [DW-1:0]       div_cnt;
   logic [8:0]          idx;
   logic                issue_done;
   logic                v1, v2;
   logic [8:0]          i1, i2;
   logic                stb, stb_last;

   logic out_rng, accept, setup_end, issue, finish;

   assign out_rng   = |(sd_lba >> LBA_BITS);
   assign accept    = (state == IDLE) && (sd_rd || sd_wr);
   assign setup_end = (state == SETUP) && (dly_cnt == SD_LAST);
   assign issue     = (state == XFER) && (div_cnt == '0) && !issue_done;
   assign finish    = (state == XFER) && stb && stb_last;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (sd_rd || sd_wr) state_nx = SETUP;
         SETUP:   if (dly_cnt == SD_LAST) state_nx = XFER;
         XFER:    if (stb && stb_last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Each issued index travels a 2-stage pipe (v1, v2) so read and write strobes
   // land at the same offset: store/buffer address in stage 1, data sampled at end of stage 2.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sd_ack       <= 1'b0;
         sd_buff_addr <= '0;
         sd_buff_dout <= '0;
         sd_buff_wr   <= 1'b0;
         store_addr   <= '0;
         store_we     <= 1'b0;
         store_d      <= '0;
         range_err    <= 1'b0;
         lba_q        <= '0;
         is_rd        <= 1'b0;
         in_rng       <= 1'b0;
         dly_cnt      <= '0;
         div_cnt      <= '0;
         idx          <= '0;
         issue_done   <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
         i1           <= '0;
         i2           <= '0;
         stb          <= 1'b0;
         stb_last     <= 1'b0;
      end else begin
         range_err  <= 1'b0;
         sd_buff_wr <= 1'b0;
         store_we   <= 1'b0;
         stb        <= 1'b0;
         v1         <= issue;
         v2         <= v1;
         i2         <= i1;

         if (accept) begin
            lba_q     <= sd_lba[LBA_BITS-1:0];
            is_rd     <= sd_rd;
            in_rng    <= ~out_rng;
            range_err <= out_rng;
            dly_cnt   <= '0;
         end

         if (state == SETUP) dly_cnt <= dly_cnt + 1'b1;

         if (setup_end) begin
            sd_ack     <= 1'b1;
            div_cnt    <= '0;
            idx        <= '0;
            issue_done <= 1'b0;
         end

         if (state == XFER) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

         if (issue) begin
            i1         <= idx;
            idx        <= idx + 1'b1;
            issue_done <= (idx == 9'd511);
            if (!is_rd)      sd_buff_addr <= idx;
            else if (in_rng) store_addr   <= {lba_q, idx};
         end

         if (v2) begin
            stb      <= 1'b1;
            stb_last <= (i2 == 9'd511);
            if (is_rd) begin
               sd_buff_addr <= i2;
               sd_buff_dout <= in_rng ? store_q : 8'hFF;
               sd_buff_wr   <= 1'b1;
            end else begin
               store_d <= sd_buff_din;
               if (in_rng) begin
                  store_addr <= {lba_q, i2};
                  store_we   <= 1'b1;
               end
            end
         end

         if (finish) sd_ack <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_sector_server.sv
// Scoreboard bench for sd_sector_server: stimulus queues expected strobes, negedge monitors pop and compare.
module tb_sd_sector_server;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr;
   logic        sd_ack, sd_buff_wr, store_we, range_err;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout, sd_buff_din, store_d, store_q;
   logic [12:0] store_addr;

   logic [31:0] d_lba;
   logic        d_rd, d_wr;
   logic        d_ack, d_buff_wr, d_store_we, d_range_err;
   logic [8:0]  d_buff_addr;
   logic [7:0]  d_buff_dout, d_store_d;
   logic [7:0]  d_buff_din = 8'h00;
   logic [7:0]  d_store_q  = 8'h33;
   logic [12:0] d_store_addr;

   sd_sector_server u_dut (
      .clk_sys(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .store_addr(store_addr),
      .store_we(store_we), .store_d(store_d), .store_q(store_q), .range_err(range_err)
   );

   sd_sector_server #(.LBA_BITS(4), .START_DELAY(1), .STROBE_DIV(4)) u_div (
      .clk_sys(clk), .reset(reset), .sd_lba(d_lba), .sd_rd(d_rd), .sd_wr(d_wr),
      .sd_ack(d_ack), .sd_buff_addr(d_buff_addr), .sd_buff_dout(d_buff_dout),
      .sd_buff_wr(d_buff_wr), .sd_buff_din(d_buff_din), .store_addr(d_store_addr),
      .store_we(d_store_we), .store_d(d_store_d), .store_q(d_store_q), .range_err(d_range_err)
   );

   // Backing store with synchronous read, initiator buffer returning ~addr one cycle late.
   logic [7:0]  store [0:8191];
   logic        pre_we = 1'b0;
   logic [12:0] pre_a;
   logic [7:0]  pre_d;
   always @(posedge clk) begin
      if (pre_we)        store[pre_a]      <= pre_d;
      else if (store_we) store[store_addr] <= store_d;
      store_q     <= store[store_addr];
      sd_buff_din <= ~sd_buff_addr[7:0];
   end

   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int lba, input int i);
      logic [3:0] s;
      s = 4'(lba) ^ 4'd3;
      return 8'(i) ^ 8'h5A ^ {s, 4'h0};
   endfunction

   logic [16:0] rd_q [$];
   logic [20:0] wr_q [$];
   logic [20:0] e;
   int  n_rdstb = 0, n_wrstb = 0, n_ackfall = 0, n_rerr = 0, oor_moves = 0;
   logic ack_d = 1'b0;
   bit  oor_watch = 1'b0;
   int  cyc = 0, d_n = 0, d_last = 0;

   always @(negedge clk) begin
      cyc++;
      if (sd_buff_wr) begin
         n_rdstb++;
         if (rd_q.size() == 0) check("rd_unexpected_strobe", 32'(sd_buff_addr), 32'h1_0000);
         else begin
            e = 21'(rd_q.pop_front());
            check("rd_byte", 32'({sd_ack, sd_buff_addr, sd_buff_dout}), 32'({1'b1, e[16:0]}));
         end
      end
      if (store_we) begin
         n_wrstb++;
         if (wr_q.size() == 0) check("wr_unexpected_strobe", 32'(store_addr), 32'h10_0000);
         else begin
            e = wr_q.pop_front();
            check("wr_byte", 32'({sd_ack, store_addr, store_d}), 32'({1'b1, e}));
         end
      end
      if (ack_d && !sd_ack) n_ackfall++;
      ack_d = sd_ack;
      if (range_err) n_rerr++;
      if (oor_watch && store_addr != 13'd0) oor_moves++;
      if (d_buff_wr) begin
         d_n++;
         if (d_n > 1) check("div_strobe_gap", 32'(cyc - d_last), 32'd4);
         check("div_byte", 32'({d_ack, d_buff_dout}), 32'h133);
         d_last = cyc;
      end
   end

   task automatic request(input logic [31:0] lba, input bit rd, input bit wr,
                          output int rise_lat, output int dur);
      int n, m;
      @(negedge clk);
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      n = 0;
      while (sd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("ack_rise_timeout", 32'(n), 32'd0);
      sd_rd = 1'b0; sd_wr = 1'b0;
      m = 0;
      while (sd_ack === 1'b1 && m < 3000) begin @(negedge clk); m++; end
      if (m >= 3000) check("ack_fall_timeout", 32'(m), 32'd0);
      rise_lat = n;
      dur = n + m;
   endtask

   task automatic push_rd(input int lba, input int mode);
      logic [7:0] b;
      for (int i = 0; i < 512; i++) begin
         if (mode == 1)                 b = 8'hFF;
         else if (lba == 15)            b = ~8'(i);
         else if (mode == 2 && i <= 100) b = ~8'(i);
         else                           b = pat(lba, i);
         rd_q.push_back({9'(i), b});
      end
   endtask

   task automatic push_wr(input int lba);
      for (int i = 0; i < 512; i++) wr_q.push_back({13'(lba * 512 + i), ~8'(i)});
   endtask

   initial begin
      int lat, dur, r0, w0, a0, errs, n;
      reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
      d_lba = '0; d_rd = 1'b0; d_wr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack",       32'(sd_ack),       32'd0);
      check("rst_buff_addr", 32'(sd_buff_addr), 32'd0);
      check("rst_buff_dout", 32'(sd_buff_dout), 32'd0);
      check("rst_buff_wr",   32'(sd_buff_wr),   32'd0);
      check("rst_store_addr",32'(store_addr),   32'd0);
      check("rst_store_we",  32'(store_we),     32'd0);
      check("rst_store_d",   32'(store_d),      32'd0);
      check("rst_range_err", 32'(range_err),    32'd0);

      pre_we = 1'b1;
      for (int a = 0; a < 8192; a++) begin
         pre_a = 13'(a); pre_d = pat(a >> 9, a & 511);
         @(negedge clk);
      end
      pre_we = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // read sector 3
      r0 = n_rdstb; w0 = n_wrstb;
      push_rd(3, 0);
      request(32'd3, 1'b1, 1'b0, lat, dur);
      check("rd3_ack_lat", 32'(lat), 32'd3);
      check("rd3_dur_le_518", 32'(dur <= 518), 32'd1);
      check("rd3_strobes", 32'(n_rdstb - r0), 32'd512);
      check("rd3_no_we", 32'(n_wrstb - w0), 32'd0);
      check("rd3_queue_left", 32'(rd_q.size()), 32'd0);

      // write sector 15
      w0 = n_wrstb; r0 = n_rdstb;
      push_wr(15);
      request(32'd15, 1'b0, 1'b1, lat, dur);
      check("wr15_ack_lat", 32'(lat), 32'd3);
      check("wr15_strobes", 32'(n_wrstb - w0), 32'd512);
      check("wr15_no_buff_wr", 32'(n_rdstb - r0), 32'd0);
      check("wr15_queue_left", 32'(wr_q.size()), 32'd0);
      errs = 0;
      for (int i = 0; i < 512; i++) if (store[15*512 + i] !== ~8'(i)) errs++;
      check("sec15_image", 32'(errs), 32'd0);
      errs = 0;
      for (int i = 0; i < 512; i++) if (store[14*512 + i] !== pat(14, i)) errs++;
      check("sec14_untouched", 32'(errs), 32'd0);

      // full backup loop
      r0 = n_rdstb; a0 = n_ackfall;
      for (int l = 0; l < 16; l++) begin
         push_rd(l, 0);
         request(32'(l), 1'b1, 1'b0, lat, dur);
      end
      check("loop_ack_pulses", 32'(n_ackfall - a0), 32'd16);
      check("loop_strobes", 32'(n_rdstb - r0), 32'd8192);
      check("loop_queue_left", 32'(rd_q.size()), 32'd0);

      // reset in the middle of a sector-2 write
      push_wr(2);
      @(negedge clk);
      sd_lba = 32'd2; sd_wr = 1'b1;
      n = 0;
      while (sd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      sd_wr = 1'b0;
      while (!(store_we && store_addr == 13'(2*512 + 100)) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) check("byte100_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_ack", 32'(sd_ack), 32'd0);
      check("midrst_we", 32'(store_we), 32'd0);
      wr_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      errs = 0;
      for (int i = 0; i < 512; i++)
         if (store[2*512 + i] !== ((i <= 100) ? ~8'(i) : pat(2, i))) errs++;
      check("sec2_partial", 32'(errs), 32'd0);

      // out of range with simultaneous rd/wr: read wins, 0xFF, no store traffic
      r0 = n_rerr; w0 = n_wrstb; oor_moves = 0;
      oor_watch = 1'b1;
      push_rd(16, 1);
      request(32'd16, 1'b1, 1'b1, lat, dur);
      oor_watch = 1'b0;
      check("oor_ack_lat", 32'(lat), 32'd3);
      check("oor_range_err", 32'(n_rerr - r0), 32'd1);
      check("oor_no_we", 32'(n_wrstb - w0), 32'd0);
      check("oor_store_addr_idle", 32'(oor_moves), 32'd0);
      check("oor_queue_left", 32'(rd_q.size()), 32'd0);

      // normal read after reset
      r0 = n_rerr;
      push_rd(2, 2);
      request(32'd2, 1'b1, 1'b0, lat, dur);
      check("post_rst_ack_lat", 32'(lat), 32'd3);
      check("post_rst_queue_left", 32'(rd_q.size()), 32'd0);
      check("post_rst_no_range_err", 32'(n_rerr - r0), 32'd0);

      // STROBE_DIV=4, START_DELAY=1 instance
      @(negedge clk);
      d_lba = 32'd1; d_rd = 1'b1;
      n = 0;
      while (d_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("div_ack_lat", 32'(n), 32'd2);
      d_rd = 1'b0;
      n = 0;
      while (d_ack === 1'b1 && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) check("div_ack_fall_timeout", 32'(n), 32'd0);
      check("div_strobes", 32'(d_n), 32'd512);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
